// File: rtl/lcd_rd_prefetch_if.sv
// lcd_rd_prefetch_if: SDRAM burst-read and LCD pop/status signals of lcd_rd_prefetch.
// master = prefetch buffer; slave = SDRAM controller plus lcd_driver. LCD_RD_UNDERRUN_CNT_EN adds underrun_cnt.
interface lcd_rd_prefetch_if #(
    parameter int DATA_W = 96,
    parameter int ADDR_W = 24,
    parameter int LVL_W  = 5
);
    logic              sdr_addr_set;
    logic              lcd_rden;
    logic [DATA_W-1:0] lcd_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [LVL_W-1:0]  fifo_level;
    logic              underrun;
`ifdef LCD_RD_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;

    modport master (
        input  sdr_addr_set, lcd_rden, rd_ack, rd_valid, rd_data,
        output lcd_data, rd_req, rd_addr, fifo_level, underrun, underrun_cnt
    );
    modport slave (
        output sdr_addr_set, lcd_rden, rd_ack, rd_valid, rd_data,
        input  lcd_data, rd_req, rd_addr, fifo_level, underrun, underrun_cnt
    );
`else
    modport master (
        input  sdr_addr_set, lcd_rden, rd_ack, rd_valid, rd_data,
        output lcd_data, rd_req, rd_addr, fifo_level, underrun
    );
    modport slave (
        output sdr_addr_set, lcd_rden, rd_ack, rd_valid, rd_data,
        input  lcd_data, rd_req, rd_addr, fifo_level, underrun
    );
`endif
endinterface

// File: rtl/lcd_rd_prefetch.sv
// lcd_rd_prefetch: SDRAM burst-read prefetch into a show-ahead FIFO; head presented on lcd_data.
// Latency: a pushed word into an empty FIFO is on lcd_data the next cycle; a pop shows the new head next cycle.
// Backpressure: a burst is requested only when all of it fits; LCD_RD_UNDERRUN_CNT_EN adds underrun_cnt.
module lcd_rd_prefetch #(
    parameter int DATA_W      = 96,
    parameter int DEPTH       = 16,
    parameter int BURST_LEN   = 8,
    parameter int ADDR_W      = 24,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 32640
) (
    input  logic               clk_lcd,
    input  logic               lcd_rst_n,
    lcd_rd_prefetch_if.master  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, FILL, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] offset, offset_nxt, offset_wrap;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [LVL_W-1:0]  level, inflight, free;
    logic [DATA_W-1:0] head;
    logic              underrun;
    logic              flush, push, pop, rden_empty, last_beat;

    assign flush       = bus.sdr_addr_set;
    assign last_beat   = (beat == BEAT_W'(BURST_LEN - 1));
    // A controller that overruns the credit loses the word instead of corrupting the FIFO.
    assign push        = (state == FILL) && bus.rd_valid && !flush && (level != LVL_W'(DEPTH));
    assign pop         = bus.lcd_rden && (level != '0) && !flush;
    assign rden_empty  = bus.lcd_rden && (level == '0) && !flush;
    assign inflight    = (state == FILL) ? (LVL_W'(BURST_LEN) - LVL_W'(beat)) : '0;
    assign free        = LVL_W'(DEPTH) - level - inflight;
    assign offset_wrap = (offset == ADDR_W'(FRAME_WORDS - BURST_LEN)) ? '0
                                                                      : offset + ADDR_W'(BURST_LEN);
    assign rd_ptr_nxt  = rd_ptr + PTR_W'(1);

    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        beat_nxt   = beat;
        case (state)
            IDLE: if (!flush && free >= LVL_W'(BURST_LEN)) state_nxt = REQ;
            REQ: begin
                if (bus.rd_ack) begin
                    state_nxt  = flush ? DRAIN : FILL;
                    offset_nxt = offset_wrap;
                end else if (flush) begin
                    state_nxt = IDLE;
                end
            end
            FILL, DRAIN: begin
                // Beats are counted even under flush so the burst always completes.
                if (bus.rd_valid) begin
                    beat_nxt = last_beat ? '0 : beat + BEAT_W'(1);
                    if (last_beat)  state_nxt = IDLE;
                    else if (flush) state_nxt = DRAIN;
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) offset_nxt = '0;
    end

    always_ff @(posedge clk_lcd or negedge lcd_rst_n) begin
        if (!lcd_rst_n) begin
            state  <= IDLE;
            offset <= '0;
            beat   <= '0;
        end else begin
            state  <= state_nxt;
            offset <= offset_nxt;
            beat   <= beat_nxt;
        end
    end

    always_ff @(posedge clk_lcd) begin
        if (push) mem[wr_ptr] <= bus.rd_data;
    end

    always_ff @(posedge clk_lcd or negedge lcd_rst_n) begin
        if (!lcd_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            head     <= '0;
            underrun <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            head     <= '0;
            underrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr_nxt;
            level <= level + LVL_W'(push) - LVL_W'(pop);
            // Head register: next stored word, or the incoming word when it becomes the head.
            if (pop && level > LVL_W'(1))
                head <= mem[rd_ptr_nxt];
            else if (push && ((level == '0) || (pop && level == LVL_W'(1))))
                head <= bus.rd_data;
            if (rden_empty) underrun <= 1'b1;
        end
    end

`ifdef LCD_RD_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;

    always_ff @(posedge clk_lcd or negedge lcd_rst_n) begin
        if (!lcd_rst_n)
            underrun_cnt <= '0;
        else if (rden_empty && underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end

    assign bus.underrun_cnt = underrun_cnt;
`endif

    assign bus.lcd_data   = head;
    assign bus.rd_req     = (state == REQ);
    assign bus.rd_addr    = ADDR_W'(BASE_ADDR) + offset;
    assign bus.fifo_level = level;
    assign bus.underrun   = underrun;
endmodule

// File: tb/tb_lcd_rd_prefetch.sv
// Directed bench for lcd_rd_prefetch: burst fill, frame wrap, underrun, flush-in-fill, push+pop, async reset.
// A small frame (64 words) keeps the wrap test short; an auto controller serves the streaming test.
module tb_lcd_rd_prefetch;
    localparam int DW = 96;
    localparam int AW = 24;
    localparam int LW = 5;
    localparam int FW = 64;

    logic clk_lcd = 1'b0;
    logic lcd_rst_n;
    always #5 clk_lcd = ~clk_lcd;

    lcd_rd_prefetch_if #(.DATA_W(DW), .ADDR_W(AW), .LVL_W(LW)) bus ();

    lcd_rd_prefetch #(.FRAME_WORDS(FW)) dut (
        .clk_lcd   (clk_lcd),
        .lcd_rst_n (lcd_rst_n),
        .bus       (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic          man_ack   = 1'b0;
    logic          man_valid = 1'b0;
    logic [DW-1:0] man_data  = '0;
    logic          ctl_en    = 1'b0;
    logic          ctl_ack   = 1'b0;
    logic          ctl_valid = 1'b0;
    logic [DW-1:0] ctl_data  = '0;
    int            ctl_beats = 0;
    int            ctl_addr  = 0;
    int            exp_req   = 0;
    int            n_bursts  = 0;
    logic          saw_wrap  = 1'b0;

    assign bus.rd_ack   = man_ack | ctl_ack;
    assign bus.rd_valid = man_valid | ctl_valid;
    assign bus.rd_data  = ctl_valid ? ctl_data : man_data;

    function automatic logic [DW-1:0] mk(int a);
        return {24'hABCDEF, 48'h0, 24'(a + 1)};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_lcd);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!bus.rd_req && n < 50) begin
            tick();
            n++;
        end
        check("req_seen", 96'(bus.rd_req), 96'(1));
    endtask

    task automatic do_ack();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
    endtask

    task automatic beats(input int a, input int n);
        for (int i = 0; i < n; i++) begin
            man_valid = 1'b1;
            man_data  = mk(a + i);
            tick();
        end
        man_valid = 1'b0;
    endtask

    // Instant-ack controller: acks a visible request, then returns 8 words of that address.
    initial begin
        forever begin
            @(negedge clk_lcd);
            if (ctl_en || ctl_ack || ctl_valid || ctl_beats != 0) begin
                if (ctl_ack) begin
                    ctl_ack   = 1'b0;
                    ctl_beats = 8;
                end
                if (ctl_beats != 0) begin
                    ctl_valid = 1'b1;
                    ctl_data  = mk(ctl_addr);
                    ctl_addr++;
                    ctl_beats--;
                end else begin
                    ctl_valid = 1'b0;
                    if (ctl_en && bus.rd_req) begin
                        check("req_addr", 96'(bus.rd_addr), 96'(exp_req));
                        if (n_bursts >= 8 && bus.rd_addr == '0) saw_wrap = 1'b1;
                        ctl_ack  = 1'b1;
                        ctl_addr = int'(bus.rd_addr);
                        exp_req  = (exp_req + 8) % FW;
                        n_bursts++;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        lcd_rst_n        = 1'b0;
        bus.sdr_addr_set = 1'b0;
        bus.lcd_rden     = 1'b0;
        tick();
        tick();
        check("rst_req",      96'(bus.rd_req),     96'(0));
        check("rst_addr",     96'(bus.rd_addr),    96'(0));
        check("rst_data",     bus.lcd_data,        96'(0));
        check("rst_level",    96'(bus.fifo_level), 96'(0));
        check("rst_underrun", 96'(bus.underrun),   96'(0));

        // First burst: ack after 3 cycles, 8 beats.
        lcd_rst_n = 1'b1;
        tick();
        check("t1_req",  96'(bus.rd_req),  96'(1));
        check("t1_addr", 96'(bus.rd_addr), 96'(0));
        repeat (2) tick();
        check("t1_req_held", 96'(bus.rd_req), 96'(1));
        do_ack();
        check("t1_req_drop", 96'(bus.rd_req), 96'(0));
        man_valid = 1'b1;
        man_data  = mk(0);
        tick();
        check("t1_first_word",  bus.lcd_data,        mk(0));
        check("t1_first_level", 96'(bus.fifo_level), 96'(1));
        for (int i = 1; i < 8; i++) begin
            man_data = mk(i);
            tick();
        end
        man_valid = 1'b0;
        check("t1_level8", 96'(bus.fifo_level), 96'(8));
        check("t1_head",   bus.lcd_data,        mk(0));
        wait_req();
        check("t1_addr8", 96'(bus.rd_addr), 96'(8));

        // Flush while a request is pending.
        bus.sdr_addr_set = 1'b1;
        tick();
        bus.sdr_addr_set = 1'b0;
        check("fl_level", 96'(bus.fifo_level), 96'(0));
        check("fl_data",  bus.lcd_data,        96'(0));
        check("fl_req",   96'(bus.rd_req),     96'(0));

        // Streaming: pop every 4th cycle past a frame boundary.
        exp_req = 0;
        ctl_en  = 1'b1;
        n = 0;
        while (bus.fifo_level == '0 && n < 100) begin
            tick();
            n++;
        end
        check("t2_fill", 96'(bus.fifo_level != '0), 96'(1));
        for (int k = 0; k < 80; k++) begin
            check("t2_word", bus.lcd_data, mk(k % FW));
            bus.lcd_rden = 1'b1;
            tick();
            bus.lcd_rden = 1'b0;
            repeat (3) tick();
        end
        check("t2_underrun", 96'(bus.underrun), 96'(0));
        check("t2_wrap",     96'(saw_wrap),     96'(1));
        ctl_en = 1'b0;
        repeat (2) tick();
        n = 0;
        while ((ctl_beats != 0 || ctl_ack || ctl_valid) && n < 50) begin
            tick();
            n++;
        end
        check("t2_ctl_idle", 96'(ctl_beats != 0 || ctl_ack || ctl_valid), 96'(0));
        bus.sdr_addr_set = 1'b1;
        tick();
        bus.sdr_addr_set = 1'b0;

        // Drain with continuous pops, then 3 pops on empty.
        wait_req();
        check("t3_addr0", 96'(bus.rd_addr), 96'(0));
        do_ack();
        beats(0, 8);
        check("t3_level8", 96'(bus.fifo_level), 96'(8));
        bus.lcd_rden = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("t3_head", bus.lcd_data, mk(k));
            tick();
        end
        check("t3_empty",       96'(bus.fifo_level), 96'(0));
        check("t3_no_underrun", 96'(bus.underrun),   96'(0));
        repeat (3) tick();
        bus.lcd_rden = 1'b0;
        check("t3_underrun",   96'(bus.underrun),   96'(1));
        check("t3_data_held",  bus.lcd_data,        mk(7));
        check("t3_level_zero", 96'(bus.fifo_level), 96'(0));
`ifdef LCD_RD_UNDERRUN_CNT_EN
        check("t3_underrun_cnt", 96'(bus.underrun_cnt), 96'(3));
`endif

        // Flush after 3 of 8 beats: the other 5 are discarded.
        wait_req();
        check("t4_addr8", 96'(bus.rd_addr), 96'(8));
        do_ack();
        beats(8, 3);
        check("t4_level3", 96'(bus.fifo_level), 96'(3));
        bus.sdr_addr_set = 1'b1;
        tick();
        bus.sdr_addr_set = 1'b0;
        check("t4_fl_level",    96'(bus.fifo_level), 96'(0));
        check("t4_fl_data",     bus.lcd_data,        96'(0));
        check("t4_fl_underrun", 96'(bus.underrun),   96'(0));
        check("t4_fl_req",      96'(bus.rd_req),     96'(0));
        beats(11, 5);
        check("t4_drain_level", 96'(bus.fifo_level), 96'(0));
        check("t4_drain_req",   96'(bus.rd_req),     96'(0));
        wait_req();
        check("t4_addr0", 96'(bus.rd_addr), 96'(0));
`ifdef LCD_RD_UNDERRUN_CNT_EN
        check("t4_cnt_kept", 96'(bus.underrun_cnt), 96'(3));
`endif

        // Simultaneous push and pop at level 5.
        do_ack();
        beats(0, 5);
        check("t5_level5", 96'(bus.fifo_level), 96'(5));
        check("t5_head0",  bus.lcd_data,        mk(0));
        man_valid    = 1'b1;
        man_data     = mk(5);
        bus.lcd_rden = 1'b1;
        tick();
        bus.lcd_rden = 1'b0;
        check("t5_level_same", 96'(bus.fifo_level), 96'(5));
        check("t5_head1",      bus.lcd_data,        mk(1));
        man_data = mk(6);
        tick();
        man_valid = 1'b0;
        check("t5_level6", 96'(bus.fifo_level), 96'(6));

        // Asynchronous reset mid-burst, observed before the next clock edge.
        #2;
        lcd_rst_n = 1'b0;
        #1;
        check("t6_req",      96'(bus.rd_req),     96'(0));
        check("t6_addr",     96'(bus.rd_addr),    96'(0));
        check("t6_data",     bus.lcd_data,        96'(0));
        check("t6_level",    96'(bus.fifo_level), 96'(0));
        check("t6_underrun", 96'(bus.underrun),   96'(0));
`ifdef LCD_RD_UNDERRUN_CNT_EN
        check("t6_cnt", 96'(bus.underrun_cnt), 96'(0));
`endif
        tick();
        lcd_rst_n = 1'b1;
        wait_req();
        check("t6_addr_base", 96'(bus.rd_addr), 96'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
